fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO, running in the FIFO read clock domain.
- Pops narrow WIDTH-bit words from the FIFO's first-word-fall-through read port and packs RATIO consecutive words into one wide word.
- Presents wide words on a valid/ready stream to the downstream datapath.
- A flush request emits a partially filled word, with lane-valid flags, at end of burst.

Parameters:
- WIDTH, 8, bits per FIFO word; must match the FIFO data width.
- RATIO, 4, FIFO words per output word; must be at least 2.
- CW, $clog2(RATIO), lane counter width (derived; not overridable).

Ports:
- clk  in  1  read-domain clock, the same clock as the FIFO read side.
- reset  in  1  asynchronous, active-low.
- fifo_dout  in  WIDTH  FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe; combinational.
- flush  in  1  single-cycle pulse requesting emission of a partial word.
- m_data  out  WIDTH*RATIO  packed word; lane 0 occupies bits [WIDTH-1:0].
- m_keep  out  RATIO  per-lane valid; always thermometer-coded from bit 0.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset (reset=0):
  - m_valid=0, m_data=0, m_keep=0.
  - Lane count cnt=0, accumulator=0, state=FILL.
  - fifo_rd_en is forced 0 while reset is low.
- out_free = ~m_valid | m_ready.
- Pop rule: fifo_rd_en = ~fifo_empty & (state==FILL) & ~(cnt==RATIO-1 & ~out_free).
- A pop occurs on a clk edge where fifo_rd_en=1. fifo_dout is captured into lane cnt, then cnt increments.
- Completion: a pop with cnt==RATIO-1 loads the output register in the same edge and sets cnt=0.
  - m_data = accumulated lanes 0..RATIO-2 plus fifo_dout in lane RATIO-1.
  - m_keep = all ones, m_valid=1.
- Latency: the last-lane pop edge gives m_valid=1 in the next cycle.
- Throughput: one pop per cycle sustained; one wide word every RATIO cycles when m_ready=1.
- Output hold: while m_valid=1 and m_ready=0, m_data and m_keep are stable. m_valid clears on an accept edge unless a new word loads on that same edge.
- Filling continues into the accumulator while the output is held. Only the last-lane pop stalls.
- State machine: FILL, FLUSH.
  - FILL to FLUSH: flush=1 on an edge with cnt>0, or with a pop at cnt>=1.
    - A word popped on the flush edge is included in the flushed word.
    - If that pop completes a full word (cnt==RATIO-1), the full word is emitted normally and the state stays FILL.
  - flush=1 with cnt==0 and no pop is ignored.
  - FLUSH: no pops. When out_free, the output loads as follows, then cnt=0, accumulator=0, and the state returns to FILL:
    - m_data = the accumulated lanes, with unfilled lanes zero.
    - m_keep = (1<<cnt)-1.
    - m_valid = 1.
  - flush pulses during FLUSH are ignored.
- Arithmetic: cnt is CW bits wide and wraps RATIO-1 to 0 only via the completion or flush paths. RATIO need not be a power of 2.
- Unused lanes of any emitted word are 0. The accumulator clears after each emission.
- Reset mid-operation discards the partial word and any held output immediately (asynchronous).

Decomposition:
- Shared package fifo_pkg:
  - typedef packer_state_t {ST_FILL, ST_FLUSH}.
  - function keep_from_count(cnt) returning a thermometer mask.
- No sub-module is required. The lane write decoder stays inline.

Test Plan:
- RATIO=4, WIDTH=8, m_ready=1, push 0x11,0x22,0x33,0x44 -> m_data=0x44332211 and m_keep=4'b1111 one cycle after the 4th pop; the FIFO ends empty.
- Push 8 words 0x01..0x08 with m_ready=0 -> m_data=0x04030201 held. fifo_rd_en drops at cnt==3 after 0x05..0x07 are popped. Raise m_ready -> next word 0x08070605.
- Push 0xAA,0xBB, then flush pulse -> m_data=0x0000BBAA, m_keep=4'b0011; state returns to FILL; a following push 0xCC lands in lane 0.
- Flush on the same edge as a pop of the 3rd word (0x01,0x02,0x03) -> m_data=0x00030201, m_keep=4'b0111. Flush on the same edge as the 4th-word pop -> a normal full word, m_keep=4'b1111.
- Flush with cnt==0 and an empty FIFO -> no m_valid pulse, and no state change out of FILL.
- Assert reset after 2 words have been popped and an output word is held -> m_valid=0, m_keep=0, fifo_rd_en=0 immediately. After release, 4 new words pack correctly starting from lane 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } packer_state_t;

  localparam int unsigned KEEP_MAX = 32;

  // Thermometer mask with the low 'cnt' bits set; callers size-cast to their lane count.
  function automatic logic [KEEP_MAX-1:0] keep_from_count(input int unsigned cnt);
    logic [KEEP_MAX-1:0] mask;
    mask = {KEEP_MAX{1'b0}};
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      mask[i] = (i < cnt);
    end
    return mask;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops narrow words from a first-word-fall-through FIFO and packs RATIO of them
// into one wide valid/ready word; flush emits a partial word with lane-valid flags.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic [WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]          cnt_r;
  logic [WIDTH*RATIO-1:0] acc_r;
  packer_state_t          state_r;

  logic                   out_free_s;
  logic                   last_lane_s;
  logic                   pop_s;
  logic [RATIO-1:0]       keep_part_s;

  // Pop decision: only the last-lane pop waits for the output register to free up.
  always_comb begin
    out_free_s  = ~m_valid | m_ready;
    last_lane_s = (cnt_r == CW'(RATIO-1));
    pop_s       = reset & ~fifo_empty & (state_r == ST_FILL) & ~(last_lane_s & ~out_free_s);
    keep_part_s = RATIO'(keep_from_count(32'(cnt_r)));
    fifo_rd_en  = pop_s;
  end

  // Lane accumulation, output register and FILL/FLUSH sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {(WIDTH*RATIO){1'b0}};
      state_r <= ST_FILL;
      m_data  <= {(WIDTH*RATIO){1'b0}};
      m_keep  <= {RATIO{1'b0}};
      m_valid <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      case (state_r)
        ST_FILL: begin
          if (pop_s) begin
            if (last_lane_s) begin
              // Completing pop bypasses the accumulator into the top lane.
              m_data  <= {fifo_dout, acc_r[WIDTH*(RATIO-1)-1:0]};
              m_keep  <= {RATIO{1'b1}};
              m_valid <= 1'b1;
              cnt_r   <= {CW{1'b0}};
              acc_r   <= {(WIDTH*RATIO){1'b0}};
            end else begin
              for (int i = 0; i < RATIO; i++) begin
                if (cnt_r == CW'(i)) begin
                  acc_r[i*WIDTH +: WIDTH] <= fifo_dout;
                end
              end
              cnt_r <= cnt_r + CW'(1);
              if (flush && (cnt_r != {CW{1'b0}})) begin
                state_r <= ST_FLUSH;
              end
            end
          end else if (flush && (cnt_r != {CW{1'b0}})) begin
            state_r <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (out_free_s) begin
            m_data  <= acc_r;
            m_keep  <= keep_part_s;
            m_valid <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {(WIDTH*RATIO){1'b0}};
            state_r <= ST_FILL;
          end
        end
        default: begin
          state_r <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized and directed bench for fifo_rd_packer with a word-level packing model
// and a scoreboard drained by an independent output monitor.
module tb_fifo_rd_packer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [WIDTH-1:0]       fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic                   flush;
  logic [WIDTH*RATIO-1:0] m_data;
  logic [RATIO-1:0]       m_keep;
  logic                   m_valid;
  logic                   m_ready;

  typedef struct {
    logic [WIDTH*RATIO-1:0] d;
    logic [RATIO-1:0]       k;
  } exp_t;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] fq[$];
  int               pend[$];
  exp_t             exp_q[$];

  fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // Pack the pending words lane by lane into one expected output word.
  task automatic emit();
    exp_t e;
    int n;
    n = pend.size();
    e.d = '0;
    for (int i = 0; i < n; i++) e.d = e.d | ((WIDTH*RATIO)'(pend[i]) << (WIDTH*i));
    e.k = RATIO'((1 << n) - 1);
    exp_q.push_back(e);
    pend.delete();
  endtask

  // One clock: inputs are stable from here to the edge, so the model reads them at negedge.
  task automatic step(input bit fl);
    bit pop_now;
    int pb;
    flush = fl;
    @(negedge clk);
    pop_now = fifo_rd_en;
    pb = pend.size();
    if (pop_now) begin
      chk("pop_while_empty", 64'(fq.size() == 0), 64'd0);
      if (fq.size() != 0) pend.push_back(int'(fq[0]));
    end
    if (pop_now && pb == RATIO-1) emit();
    else if (fl && pb > 0) emit();
    @(posedge clk);
    #1;
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    refresh();
    flush = 1'b0;
  endtask

  // Monitor: every accepted output word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h, expected no word", m_data, m_keep);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("m_data", 64'(m_data), 64'(e.d));
        chk("m_keep", 64'(m_keep), 64'(e.k));
      end
    end
  end

  initial begin
    flush   = 1'b0;
    m_ready = 1'b0;
    refresh();
    push(8'h11);
    #12;
    chk("reset_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("reset_valid", 64'(m_valid), 64'd0);
    chk("reset_data", 64'(m_data), 64'd0);
    chk("reset_keep", 64'(m_keep), 64'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    m_ready = 1'b1;

    // Basic pack and one-cycle latency
    push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("lat_valid", 64'(m_valid), 64'd1);
    chk("lat_data", 64'(m_data), 64'h44332211);
    chk("lat_fifo_empty", 64'(fq.size()), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Backpressure: one word held, accumulator fills to the last lane then stalls
    m_ready = 1'b0;
    for (int w = 1; w <= 8; w++) push(8'(w));
    for (int i = 0; i < 12; i++) step(1'b0);
    chk("hold_valid", 64'(m_valid), 64'd1);
    chk("hold_data", 64'(m_data), 64'h04030201);
    chk("hold_stall", 64'(fifo_rd_en), 64'd0);
    chk("hold_left", 64'(fq.size()), 64'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0);

    // Partial flush after two words, then refill from lane 0
    push(8'hAA); push(8'hBB);
    step(1'b0); step(1'b0); step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    push(8'hCC); push(8'hDD); push(8'hEE); push(8'hFF);
    for (int i = 0; i < 6; i++) step(1'b0);

    // Flush coinciding with a 3rd-word pop, then with a completing pop
    push(8'h01); push(8'h02); push(8'h03);
    step(1'b0); step(1'b0); step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    push(8'h05); push(8'h06); push(8'h07); push(8'h08);
    step(1'b0); step(1'b0); step(1'b0); step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Idle flush with nothing accumulated must not emit anything
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("idle_flush_valid", 64'(m_valid), 64'd0);
    end
    push(8'h9A); push(8'h9B); push(8'h9C); push(8'h9D);
    for (int i = 0; i < 6; i++) step(1'b0);

    // Reset with a held word and two words in the accumulator
    m_ready = 1'b0;
    for (int w = 0; w < 6; w++) push(8'h60 + 8'(w));
    for (int i = 0; i < 8; i++) step(1'b0);
    reset = 1'b0;
    fq.delete();
    pend.delete();
    exp_q.delete();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    #1;
    chk("midreset_valid", 64'(m_valid), 64'd0);
    chk("midreset_keep", 64'(m_keep), 64'd0);
    chk("midreset_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b0);

    // Randomized traffic, backpressure and flushes
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 16) push(8'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 15) == 0);
    end

    // Drain: flush any leftover partial word, bounded by a cycle budget
    m_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (fq.size() == 0 && pend.size() == 0 && exp_q.size() == 0 && !m_valid) break;
      step(fq.size() == 0 && pend.size() > 0);
    end
    chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(m_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
